// File: rtl/store_buffer_if.sv
// Bundles the pipeline-side store/load handshake and the data-memory port
// of the store buffer. The buffer connects through the slave modport.
interface store_buffer_if;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_mode;
   logic [31:0] st_pc;
   logic        st_ready;

   logic        ld_req;
   logic [31:0] ld_addr;
   logic [2:0]  ld_mode;
   logic [31:0] ld_pc;
   logic        ld_stall;

   logic        fwd_valid;
   logic [31:0] fwd_data;

   logic [31:0] dm_read_addr;
   logic [31:0] dm_write_addr;
   logic [31:0] dm_write_data;
   logic        dm_write_enable;
   logic [2:0]  dm_mode;
   logic [31:0] dm_curr_pc;

   logic        empty;

   modport master (
      output st_valid, st_addr, st_data, st_mode, st_pc,
      output ld_req, ld_addr, ld_mode, ld_pc,
      input  st_ready, ld_stall, fwd_valid, fwd_data,
      input  dm_read_addr, dm_write_addr, dm_write_data, dm_write_enable,
      input  dm_mode, dm_curr_pc, empty
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_mode, st_pc,
      input  ld_req, ld_addr, ld_mode, ld_pc,
      output st_ready, ld_stall, fwd_valid, fwd_data,
      output dm_read_addr, dm_write_addr, dm_write_data, dm_write_enable,
      output dm_mode, dm_curr_pc, empty
   );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between the MEM stage and data memory. Stores retire
// one per cycle whenever the memory port is not claimed by a load; loads that
// overlap a pending store word are stalled until it retires.
// Optional macro STORE_BUF_FORWARD_EN: aligned word loads hitting a youngest
// aligned word store are served by forwarding instead of stalling.
// Access-mode encoding: NONE=0, W=1, H=2, HU=3, B=4, BU=5.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave bus
);
   localparam logic [2:0] DM_NONE = 3'd0;
   localparam logic [2:0] DM_W    = 3'd1;
   localparam logic [2:0] DM_H    = 3'd2;
   localparam logic [2:0] DM_B    = 3'd4;

   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [2:0]       mode_q [DEPTH];
   logic [2:0]       mode_d [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      pc_d   [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             full, is_empty, hazard, fwd_ok, stall, drain, push;
   logic [PTR_W-1:0] idx;
`ifdef STORE_BUF_FORWARD_EN
   logic [PTR_W-1:0] yng_idx;
`endif

   // Scan occupied entries oldest-to-youngest for a word overlap with the load
   always_comb begin
      idx    = '0;
      hazard = 1'b0;
`ifdef STORE_BUF_FORWARD_EN
      yng_idx = head_q;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (((PTR_W+1)'(k) < count_q) && (addr_q[idx][31:2] == bus.ld_addr[31:2])) begin
            hazard = bus.ld_req;
`ifdef STORE_BUF_FORWARD_EN
            yng_idx = idx;
`endif
         end
      end
   end

   // Stall / forward / drain decisions; reset suppresses every action
   always_comb begin
      full     = (count_q == (PTR_W+1)'(DEPTH));
      is_empty = (count_q == '0);
`ifdef STORE_BUF_FORWARD_EN
      fwd_ok = hazard && (bus.ld_mode == DM_W) && (bus.ld_addr[1:0] == 2'b00) &&
               (mode_q[yng_idx] == DM_W) && (addr_q[yng_idx][1:0] == 2'b00);
`else
      fwd_ok = 1'b0;
`endif
      // A full queue always stalls the load so stores can make progress
      stall = !reset && bus.ld_req && ((hazard && !fwd_ok) || full);
      drain = !reset && !is_empty && (!bus.ld_req || stall);
      push  = !reset && bus.st_valid && !full &&
              ((bus.st_mode == DM_W) || (bus.st_mode == DM_H) || (bus.st_mode == DM_B));
   end

   // Next queue state: push at tail, pop at head, count tracks the difference
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      mode_d  = mode_q;
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         addr_d[tail_q] = bus.st_addr;
         data_d[tail_q] = bus.st_data;
         mode_d[tail_q] = bus.st_mode;
         pc_d[tail_q]   = bus.st_pc;
         tail_d         = tail_q + 1'b1;
      end
      if (drain) begin
         head_d = head_q + 1'b1;
      end
      case ({push, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Queue state registers; reset empties the queue and clears storage
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            mode_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         pc_q    <= pc_d;
      end
   end

   // Memory port and pipeline-facing outputs; head entry owns the port while draining
   always_comb begin
      bus.st_ready        = reset || !full;
      bus.empty           = reset || is_empty;
      bus.ld_stall        = stall;
      bus.fwd_valid       = !reset && bus.ld_req && fwd_ok && !full;
      bus.fwd_data        = bus.fwd_valid ? data_q[yng_sel()] : 32'h0;
      bus.dm_read_addr    = bus.ld_addr;
      bus.dm_write_enable = drain;
      bus.dm_write_addr   = addr_q[head_q];
      bus.dm_write_data   = data_q[head_q];
      bus.dm_mode         = (!reset && bus.ld_req) ? bus.ld_mode : DM_NONE;
      bus.dm_curr_pc      = bus.ld_pc;
      if (drain) begin
         bus.dm_mode    = mode_q[head_q];
         bus.dm_curr_pc = pc_q[head_q];
      end
   end

   // Entry index supplying forwarded data (youngest match when forwarding exists)
   function automatic logic [PTR_W-1:0] yng_sel();
`ifdef STORE_BUF_FORWARD_EN
      return yng_idx;
`else
      return head_q;
`endif
   endfunction
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the store buffer.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam logic [2:0] DM_NONE = 3'd0;
   localparam logic [2:0] DM_W    = 3'd1;
   localparam logic [2:0] DM_H    = 3'd2;
   localparam logic [2:0] DM_B    = 3'd4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  mode;
      logic [31:0] pc;
   } entry_t;

   logic   clk = 1'b0;
   logic   reset;
   int     total = 0;
   int     bad = 0;
   entry_t q[$];
   bit     exp_drain, exp_push;

   store_buffer_if bus ();

   store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model at mid-cycle
   task automatic eval();
      entry_t y;
      bit hz, fw, full, stl, fv;
      @(negedge clk);
      full = (q.size() == DEPTH);
      hz = 0;
      fw = 0;
      y = '{default: '0};
      if (bus.ld_req)
         foreach (q[i])
            if (q[i].addr[31:2] == bus.ld_addr[31:2]) begin
               hz = 1;
               y = q[i];
            end
`ifdef STORE_BUF_FORWARD_EN
      if (hz && bus.ld_mode == DM_W && bus.ld_addr[1:0] == 2'b00 &&
          y.mode == DM_W && y.addr[1:0] == 2'b00) fw = 1;
`endif
      chk("dm_read_addr", bus.dm_read_addr, bus.ld_addr);
      if (reset) begin
         exp_drain = 0;
         exp_push = 0;
         chk("rst_st_ready", bus.st_ready, 1);
         chk("rst_empty", bus.empty, 1);
         chk("rst_ld_stall", bus.ld_stall, 0);
         chk("rst_we", bus.dm_write_enable, 0);
         chk("rst_dm_mode", bus.dm_mode, DM_NONE);
         chk("rst_fwd_valid", bus.fwd_valid, 0);
         chk("rst_fwd_data", bus.fwd_data, 0);
      end else begin
         stl = bus.ld_req && ((hz && !fw) || full);
         fv = bus.ld_req && fw && !full;
         exp_drain = (q.size() != 0) && (!bus.ld_req || stl);
         exp_push = bus.st_valid && !full &&
                    (bus.st_mode == DM_W || bus.st_mode == DM_H || bus.st_mode == DM_B);
         chk("st_ready", bus.st_ready, !full);
         chk("empty", bus.empty, q.size() == 0);
         chk("ld_stall", bus.ld_stall, stl);
         chk("fwd_valid", bus.fwd_valid, fv);
         chk("fwd_data", bus.fwd_data, fv ? y.data : 32'h0);
         chk("dm_write_enable", bus.dm_write_enable, exp_drain);
         if (exp_drain) begin
            chk("dm_write_addr", bus.dm_write_addr, q[0].addr);
            chk("dm_write_data", bus.dm_write_data, q[0].data);
            chk("dm_mode_st", bus.dm_mode, q[0].mode);
            chk("dm_curr_pc_st", bus.dm_curr_pc, q[0].pc);
         end else begin
            chk("dm_mode_ld", bus.dm_mode, bus.ld_req ? bus.ld_mode : DM_NONE);
            chk("dm_curr_pc_ld", bus.dm_curr_pc, bus.ld_pc);
         end
      end
   endtask

   // Clock edge: apply the model's pop/push, then let outputs settle
   task automatic adv();
      entry_t e;
      e.addr = bus.st_addr;
      e.data = bus.st_data;
      e.mode = bus.st_mode;
      e.pc   = bus.st_pc;
      @(posedge clk);
      if (reset) q.delete();
      else begin
         if (exp_drain) void'(q.pop_front());
         if (exp_push) q.push_back(e);
      end
      #1;
   endtask

   task automatic cycle();
      eval();
      adv();
   endtask

   task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
      bus.st_valid = v;
      bus.st_addr  = a;
      bus.st_data  = d;
      bus.st_mode  = m;
      bus.st_pc    = $urandom;
   endtask

   task automatic set_ld(input bit r, input logic [31:0] a, input logic [2:0] m);
      bus.ld_req  = r;
      bus.ld_addr = a;
      bus.ld_mode = m;
      bus.ld_pc   = $urandom;
   endtask

   initial begin
      reset = 1'b1;
      set_st(0, 0, 0, DM_NONE);
      set_ld(0, 0, DM_NONE);
      cycle();
      cycle();
      reset = 1'b0;

      // Single word store retires the next cycle
      set_st(1, 32'h10, 32'hDEADBEEF, DM_W);
      cycle();
      set_st(0, 0, 0, DM_NONE);
      eval();
      chk("t1_we", bus.dm_write_enable, 1);
      chk("t1_addr", bus.dm_write_addr, 32'h10);
      chk("t1_data", bus.dm_write_data, 32'hDEADBEEF);
      chk("t1_mode", bus.dm_mode, DM_W);
      adv();
      eval();
      chk("t1_empty", bus.empty, 1);
      adv();

      // Fill the queue behind a non-matching load, then full forces drain
      set_ld(1, 32'h100, DM_W);
      for (int i = 0; i < 4; i++) begin
         set_st(1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), DM_W);
         cycle();
      end
      set_st(0, 0, 0, DM_NONE);
      eval();
      chk("t2_full_ready", bus.st_ready, 0);
      chk("t2_full_stall", bus.ld_stall, 1);
      chk("t2_drain_addr", bus.dm_write_addr, 32'h200);
      adv();
      eval();
      chk("t2_ready_back", bus.st_ready, 1);
      chk("t2_no_stall", bus.ld_stall, 0);
      adv();
      set_ld(0, 0, DM_NONE);
      for (int i = 1; i < 4; i++) begin
         eval();
         chk("t2_order", bus.dm_write_addr, 32'h200 + 32'(4 * i));
         adv();
      end

      // Byte stores overlapping a word load stall it until both retire
      set_ld(1, 32'h100, DM_W);
      set_st(1, 32'h21, 32'hAB, DM_B);
      cycle();
      set_st(1, 32'h23, 32'hCD, DM_B);
      cycle();
      set_st(0, 0, 0, DM_NONE);
      set_ld(1, 32'h20, DM_W);
      eval();
      chk("t3_stall1", bus.ld_stall, 1);
      chk("t3_addr1", bus.dm_write_addr, 32'h21);
      adv();
      eval();
      chk("t3_stall2", bus.ld_stall, 1);
      adv();
      eval();
      chk("t3_release", bus.ld_stall, 0);
      chk("t3_ld_mode", bus.dm_mode, DM_W);
      adv();

      // Simultaneous push and drain keeps occupancy; retirement in push order
      set_st(1, 32'h50, 1, DM_W);
      set_ld(1, 32'h100, DM_W);
      cycle();
      set_st(1, 32'h54, 2, DM_H);
      cycle();
      set_ld(0, 0, DM_NONE);
      set_st(1, 32'h30, 3, DM_W);
      eval();
      chk("t4_a", bus.dm_write_addr, 32'h50);
      adv();
      set_st(1, 32'h34, 4, DM_W);
      eval();
      chk("t4_b", bus.dm_write_addr, 32'h54);
      adv();
      set_st(0, 0, 0, DM_NONE);
      eval();
      chk("t4_c", bus.dm_write_addr, 32'h30);
      adv();
      eval();
      chk("t4_d", bus.dm_write_addr, 32'h34);
      adv();
      cycle();

      // Reset with three pending stores discards them without writing
      set_ld(1, 32'h100, DM_W);
      for (int i = 0; i < 3; i++) begin
         set_st(1, 32'h60 + 32'(4 * i), 32'(i), DM_W);
         cycle();
      end
      set_st(0, 0, 0, DM_NONE);
      set_ld(0, 0, DM_NONE);
      reset = 1'b1;
      eval();
      chk("t5_we_rst", bus.dm_write_enable, 0);
      adv();
      reset = 1'b0;
      eval();
      chk("t5_empty", bus.empty, 1);
      chk("t5_no_write", bus.dm_write_enable, 0);
      adv();
      cycle();

      // Aligned word store followed by matching word load
      set_ld(1, 32'h100, DM_W);
      set_st(1, 32'h40, 32'h12345678, DM_W);
      cycle();
      set_st(0, 0, 0, DM_NONE);
      set_ld(1, 32'h40, DM_W);
      eval();
`ifdef STORE_BUF_FORWARD_EN
      chk("t6_stall", bus.ld_stall, 0);
      chk("t6_fwd_valid", bus.fwd_valid, 1);
      chk("t6_fwd_data", bus.fwd_data, 32'h12345678);
`else
      chk("t6_stall", bus.ld_stall, 1);
      chk("t6_fwd_valid", bus.fwd_valid, 0);
`endif
      adv();
      set_ld(0, 0, DM_NONE);
      cycle();
      cycle();

      // Non-store mode is ignored
      set_st(1, 32'h80, 32'h55, 3'd3);
      cycle();
      set_st(0, 0, 0, DM_NONE);
      eval();
      chk("t7_ignored", bus.empty, 1);
      adv();

      // Random traffic over a small address window to provoke overlaps
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         set_st($urandom_range(0, 1) == 1, 32'($urandom_range(0, 47)), $urandom,
                3'($urandom_range(0, 7)));
         set_ld($urandom_range(0, 2) != 0, 32'($urandom_range(0, 47)),
                3'($urandom_range(1, 5)));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order store queue between the MEM pipeline stage and the data memory.
- Accepts stores from the pipeline in one cycle, then retires them into data memory one per cycle whenever the memory port is not needed by a load.
- Owns the data-memory port: drives its read address, write address/data/enable, access mode and current PC.
- Detects load-after-pending-store word overlap and stalls the load until the overlapping stores have retired.

Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- PTR_W, 2: pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request from MEM stage this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data; low bits used for H/B.
- st_mode  in  3  DM_W, DM_H or DM_B.
- st_pc  in  32  PC of the store instruction.
- st_ready  out  1  queue can accept a store (not full).
- ld_req  in  1  load in MEM stage this cycle.
- ld_addr  in  32  load byte address.
- ld_mode  in  3  DM_W/H/HU/B/BU.
- ld_pc  in  32  PC of the load.
- ld_stall  out  1  load must be held this cycle.
- fwd_valid  out  1  load data supplied by forwarding (optional feature).
- fwd_data  out  32  forwarded word.
- dm_read_addr  out  32  to data memory read address.
- dm_write_addr  out  32  to data memory write address.
- dm_write_data  out  32  to data memory write data.
- dm_write_enable  out  1  to data memory write enable.
- dm_mode  out  3  to data memory access mode.
- dm_curr_pc  out  32  to data memory current PC.
- empty  out  1  no pending stores.

Behaviour:
- Circular FIFO: head/tail pointers of PTR_W bits plus a count of PTR_W+1 bits. Each entry holds addr, data, mode, pc.
- Reset (synchronous): head=tail=count=0; all entry storage cleared to 0.
- Reset-level outputs: empty=1, st_ready=1, ld_stall=0, dm_write_enable=0, dm_mode=DM_NONE, fwd_valid=0, fwd_data=0.
- st_ready = (count != DEPTH). Registered state only; a same-cycle pop does not raise st_ready.
- Push = st_valid && st_ready && st_mode in {W,H,B}. Pushes write the tail entry and advance tail at the clk edge.
  - Other st_mode values are ignored.
  - st_valid while full is not captured. The pipeline must hold the store until st_ready=1.
- Overlap hazard: ld_req && some occupied entry has addr[31:2] == ld_addr[31:2].
- ld_stall = ld_req && (hazard || count == DEPTH). A full queue gives stores priority, so there is no load starvation deadlock.
- drain = !empty && (!ld_req || ld_stall).
  - While draining: dm_write_enable=1; dm_write_addr/data/mode/curr_pc come from the head entry, combinationally. Head advances and count decrements at the clk edge.
  - While not draining: dm_write_enable=0; dm_mode = ld_req ? ld_mode : DM_NONE; dm_curr_pc = ld_pc.
- dm_read_addr = ld_addr at all times.
- Push and drain in the same cycle: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Retirement is strictly in program order, one store per cycle maximum; latency from push to memory write is at least 1 cycle.
- A store and a dependent load in the same cycle: the store is compared from the next cycle only. The pipeline never issues both in one MEM cycle.
- Misaligned stores are queued unchanged. Data memory flags them when they retire.
- Reset asserted mid-drain discards all pending stores; no write occurs in the reset cycle (dm_write_enable=0).

Optional Feature:
- Macro STORE_BUF_FORWARD_EN.
- Defined: when ld_req, ld_mode==DM_W and the youngest occupied matching entry has mode DM_W with addr[1:0]==0 and ld_addr[1:0]==0, the load is not stalled for that hazard. fwd_valid=1 and fwd_data = that entry's data.
  - Stalls caused by a full queue still apply, in which case fwd_valid=0.
  - All other hazard cases stall as normal.
- Not defined: fwd_valid and fwd_data tied to 0; every overlap stalls.

Test Plan:
- Reset, then st_valid with addr 0x10, data 0xDEADBEEF, mode W, ld_req=0 -> next cycle dm_write_enable=1, dm_write_addr 0x10, dm_write_data 0xDEADBEEF, dm_mode DM_W; empty=1 the cycle after.
- Push 4 stores while ld_req=1 to non-matching address 0x100 -> after 4th push st_ready=0 and ld_stall=1; drain starts; st_ready returns to 1 the cycle after the first pop.
- Pending byte store addr 0x21 mode B, load ld_addr 0x20 mode W -> ld_stall=1 until that entry retires, then ld_stall=0 and dm_mode=DM_W.
- Simultaneous push (addr 0x30) and drain with count=2 -> count stays 2; order of retirement equals push order (verify dm_write_addr sequence); pointers wrap after 4+ pushes.
- Reset asserted with 3 pending stores -> dm_write_enable=0 that cycle, empty=1 after, no further writes.
- With STORE_BUF_FORWARD_EN: pending W store 0x40 data 0x12345678, load W 0x40 -> ld_stall=0, fwd_valid=1, fwd_data 0x12345678. Without the macro -> ld_stall=1, fwd_valid=0.
